// File: rtl/sm4_crypt_core_if.sv
// ---------------------------------------------------------------------------
// sm4_crypt_core_if
//
// Block-level bus of the SM4 round core: input block plus direction select,
// and the result. The signal names match the core's documented port names.
//
// Handshake rules (both directions):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. The producer holds its data and valid stable until that edge. The
//   consumer may raise or lower ready at any time, and ready may depend
//   combinationally on the consumer's state. Valid never depends on ready.
//   Input side : data_valid_in / data_ready_out, payload data_in and
//                encdec_sel_in.
//   Output side: result_valid_out, payload result_out. With
//                SM4_OUT_HANDSHAKE_EN defined, result_ready_in completes the
//                output transfer. Without it, result_valid_out is a single
//                cycle pulse that cannot be back-pressured.
//
// Modports
//   master : the block source / result sink (upstream logic or testbench)
//   slave  : the SM4 core
//
// Optional feature macro: SM4_OUT_HANDSHAKE_EN
// ---------------------------------------------------------------------------
interface sm4_crypt_core_if;
    logic         encdec_sel_in;
    logic [127:0] data_in;
    logic         data_valid_in;
    logic         data_ready_out;
    logic [127:0] result_out;
    logic         result_valid_out;
`ifdef SM4_OUT_HANDSHAKE_EN
    logic         result_ready_in;
`endif

    modport master (
        output encdec_sel_in, data_in, data_valid_in,
`ifdef SM4_OUT_HANDSHAKE_EN
        output result_ready_in,
`endif
        input  data_ready_out, result_out, result_valid_out
    );

    modport slave (
        input  encdec_sel_in, data_in, data_valid_in,
`ifdef SM4_OUT_HANDSHAKE_EN
        input  result_ready_in,
`endif
        output data_ready_out, result_out, result_valid_out
    );
endinterface

// File: rtl/sm4_crypt_core.sv
// ---------------------------------------------------------------------------
// sm4_crypt_core
//
// Iterative SM4 block cipher datapath: one round per clock, 32 rounds per
// block, taking externally expanded round keys. Encrypt and decrypt differ
// only in the order in which the round keys are consumed.
//
// Ports
//   clk                 : rising-edge clock
//   reset_n             : asynchronous active-low reset
//   sm4_enable_in       : global enable; low aborts any block in flight
//   key_exp_finished_in : round keys are stable; low aborts any block in flight
//   round_keys_in       : rk_i at [32i+31:32i], i = 0..31
//   bus                 : block handshake (sm4_crypt_core_if.slave)
//   fsm_state           : debug view of the controller state
//
// Timing: accept on edge 0, rounds on edges 1..32, result registered with
// result_valid_out on edge 33, ready again in the same cycle.
//
// Optional feature macro: SM4_OUT_HANDSHAKE_EN
//   defined   : result_valid_out holds until result_ready_in is seen high
//   undefined : result_valid_out is a one-cycle pulse
// ---------------------------------------------------------------------------

// 8-bit SM4 substitution box, purely combinational.
module sm4_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [2047:0] SBOX_TABLE = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // Entry 0 sits in the top byte; ~in_byte * 8 is its bit offset.
    assign out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];
endmodule

module sm4_crypt_core (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sm4_enable_in,
    input  logic                   key_exp_finished_in,
    input  logic [1023:0]          round_keys_in,
    sm4_crypt_core_if.slave        bus,
    output logic [1:0]             fsm_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t         state;
    logic [4:0]     cnt;
    logic [127:0]   blk;        // {X(i), X(i+1), X(i+2), X(i+3)}
    logic           decrypt;
    logic [127:0]   result_q;
    logic           valid_q;

    logic           run_ok;
    logic [4:0]     rk_idx;
    logic [31:0]    rk;
    logic [31:0]    mix;
    logic [31:0]    tau;
    logic [31:0]    lin;
    logic [31:0]    x_new;
    logic [127:0]   blk_rev;

    assign run_ok              = sm4_enable_in && key_exp_finished_in;
    assign bus.data_ready_out  = (state == IDLE) && run_ok;
    assign bus.result_out      = result_q;
    assign bus.result_valid_out = valid_q;
    assign fsm_state           = state;

    // Decrypt walks the keys backwards; 31-cnt equals ~cnt in 5 bits.
    assign rk_idx = decrypt ? ~cnt : cnt;
    assign rk     = round_keys_in[{rk_idx, 5'b00000} +: 32];

    assign mix = blk[95:64] ^ blk[63:32] ^ blk[31:0] ^ rk;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sm4_sbox u_sbox (
            .in_byte  (mix[8*g +: 8]),
            .out_byte (tau[8*g +: 8])
        );
    end

    // Linear diffusion L(B) = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24.
    assign lin = tau
               ^ {tau[29:0], tau[31:30]}
               ^ {tau[21:0], tau[31:22]}
               ^ {tau[13:0], tau[31:14]}
               ^ {tau[7:0],  tau[31:8]};

    assign x_new   = blk[127:96] ^ lin;
    assign blk_rev = {blk[31:0], blk[63:32], blk[95:64], blk[127:96]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            blk      <= 128'd0;
            decrypt  <= 1'b0;
            result_q <= 128'd0;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.data_valid_in && bus.data_ready_out) begin
                        blk     <= bus.data_in;
                        decrypt <= bus.encdec_sel_in;
                        cnt     <= 5'd0;
                        state   <= ROUND;
                    end
                end

                ROUND: begin
                    if (!run_ok) begin
                        // Abandon the block; result_out keeps the last result.
                        state <= IDLE;
                    end else begin
                        blk <= {blk[95:0], x_new};
                        cnt <= cnt + 5'd1;   // wraps to 0 after round 31
                        if (cnt == 5'd31) begin
                            state <= OUT;
                        end
                    end
                end

                OUT: begin
`ifdef SM4_OUT_HANDSHAKE_EN
                    if (!run_ok) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end else if (!valid_q) begin
                        result_q <= blk_rev;
                        valid_q  <= 1'b1;
                    end else if (bus.result_ready_in) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
`else
                    if (run_ok) begin
                        result_q <= blk_rev;
                        valid_q  <= 1'b1;
                    end
                    state <= IDLE;
`endif
                end

                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sm4_crypt_core.sv
// ---------------------------------------------------------------------------
// tb_sm4_crypt_core
//
// Self-checking bench for sm4_crypt_core. A behavioural SM4 model (key
// schedule plus the 32-round cipher written over word arrays) produces the
// expected results. A vector table covers the published known-answer pair
// and random keys/blocks; hand sequences cover streaming, aborts, reset and
// the optional output handshake (SM4_OUT_HANDSHAKE_EN).
// ---------------------------------------------------------------------------
module tb_sm4_crypt_core;

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          reset_n;
    logic          sm4_enable_in;
    logic          key_exp_finished_in;
    logic [1023:0] round_keys_in;
    logic [1:0]    fsm_state;

    sm4_crypt_core_if bus ();

    sm4_crypt_core dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .sm4_enable_in       (sm4_enable_in),
        .key_exp_finished_in (key_exp_finished_in),
        .round_keys_in       (round_keys_in),
        .bus                 (bus),
        .fsm_state           (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    localparam logic [127:0] SB_ROWS [16] = '{
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };
    localparam logic [31:0] FK [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    function automatic logic [7:0] sbox_m(input logic [7:0] b);
        logic [127:0] row;
        int col;
        row = SB_ROWS[b[7:4]];
        col = 15 - int'(b[3:0]);
        return row[col*8 +: 8];
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau_m(input logic [31:0] a);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = sbox_m(a[8*j +: 8]);
        return r;
    endfunction

    function automatic logic [31:0] t_data(input logic [31:0] a);
        logic [31:0] b;
        b = tau_m(a);
        return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    endfunction

    function automatic logic [31:0] t_key(input logic [31:0] a);
        logic [31:0] b;
        b = tau_m(a);
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

    function automatic logic [1023:0] key_sched(input logic [127:0] mk);
        logic [31:0]   k [36];
        logic [31:0]   ck;
        logic [1023:0] rks;
        for (int i = 0; i < 4; i++) k[i] = mk[127 - 32*i -: 32] ^ FK[i];
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'(((4*i + j) * 7) % 256);
            k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            rks[32*i +: 32] = k[i+4];
        end
        return rks;
    endfunction

    function automatic logic [127:0] sm4_ref(input logic [1023:0] rks, input logic dec,
                                             input logic [127:0] d);
        logic [31:0] x [36];
        logic [31:0] k;
        int ki;
        for (int i = 0; i < 4; i++) x[i] = d[127 - 32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            ki = dec ? (31 - i) : i;
            k  = rks[32*ki +: 32];
            x[i+4] = x[i] ^ t_data(x[i+1] ^ x[i+2] ^ x[i+3] ^ k);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [127:0] exp_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Returns at the falling edge right after the accepting edge.
    task automatic start_block(input logic sel, input logic [127:0] din);
        int guard;
        @(negedge clk);
        bus.data_in       = din;
        bus.encdec_sel_in = sel;
        bus.data_valid_in = 1'b1;
        guard = 0;
        while (!bus.data_ready_out && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("accept_timeout", 128'(bus.data_ready_out), 128'd1);
        @(negedge clk);
        bus.data_valid_in = 1'b0;
    endtask

    // lat counts edges after the accepting edge.
    task automatic wait_result(output logic [127:0] res, output int lat, output logic got);
        lat = 0;
        while (!bus.result_valid_out && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        got = bus.result_valid_out;
        res = bus.result_out;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [127:0] key;
        logic         dec;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;

    localparam int NV = 8;
    localparam logic [127:0] KAT_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] KAT_CT  = 128'h681EDF34D206965E86B3E94F536E4246;

    vec_t         vecs [NV];
    logic [1023:0] kat_rks;
    logic [127:0] res, prev_res, cur;
    logic         got, cur_sel, accepted, prev_v;
    int           lat, n_acc, pulses, last_acc, seen;

    initial begin
        reset_n             = 1'b0;
        sm4_enable_in       = 1'b1;
        key_exp_finished_in = 1'b1;
        bus.data_in         = '0;
        bus.data_valid_in   = 1'b0;
        bus.encdec_sel_in   = 1'b0;
`ifdef SM4_OUT_HANDSHAKE_EN
        bus.result_ready_in = 1'b1;
`endif
        kat_rks       = key_sched(KAT_KEY);
        round_keys_in = kat_rks;
        check("model_rk00", 128'(kat_rks[31:0]), 128'hF12186F9);
        check("model_rk31", 128'(kat_rks[1023:992]), 128'h9124A012);

        vecs[0] = '{key: KAT_KEY, dec: 1'b0, data: KAT_KEY, exp: KAT_CT};
        vecs[1] = '{key: KAT_KEY, dec: 1'b1, data: KAT_CT,  exp: KAT_KEY};
        for (int i = 2; i < NV; i++) begin
            vecs[i].key  = rnd128();
            vecs[i].dec  = 1'($urandom_range(0, 1));
            vecs[i].data = rnd128();
            vecs[i].exp  = sm4_ref(key_sched(vecs[i].key), vecs[i].dec, vecs[i].data);
        end

        // ---- reset state and ready gating ----
        repeat (3) @(negedge clk);
        check("reset_result_out", bus.result_out, 128'd0);
        check("reset_result_valid", 128'(bus.result_valid_out), 128'd0);
        check("reset_ready", 128'(bus.data_ready_out), 128'd1);
        sm4_enable_in = 1'b0; #1;
        check("ready_enable_low", 128'(bus.data_ready_out), 128'd0);
        sm4_enable_in = 1'b1; key_exp_finished_in = 1'b0; #1;
        check("ready_keyfin_low", 128'(bus.data_ready_out), 128'd0);
        key_exp_finished_in = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;

        // ---- table of vectors ----
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            round_keys_in = key_sched(vecs[i].key);
            start_block(vecs[i].dec, vecs[i].data);
            wait_result(res, lat, got);
            check($sformatf("vec%0d_valid", i), 128'(got), 128'd1);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'd33);
            @(negedge clk);
            check($sformatf("vec%0d_pulse_end", i), 128'(bus.result_valid_out), 128'd0);
            check($sformatf("vec%0d_hold", i), bus.result_out, vecs[i].exp);
        end
        prev_res = vecs[NV-1].exp;
        round_keys_in = kat_rks;

        // ---- valid while not ready is ignored ----
        @(negedge clk);
        sm4_enable_in     = 1'b0;
        bus.data_valid_in = 1'b1;
        bus.data_in       = rnd128();
        repeat (5) @(negedge clk);
        bus.data_valid_in = 1'b0;
        sm4_enable_in     = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_valid_out) seen++;
        end
        check("ignored_no_result", 128'(seen), 128'd0);
        check("ignored_ready_back", 128'(bus.data_ready_out), 128'd1);

        // ---- continuous valid: one acceptance every 34 clocks ----
        @(negedge clk);
        cur = rnd128(); cur_sel = 1'($urandom_range(0, 1));
        bus.data_in = cur; bus.encdec_sel_in = cur_sel; bus.data_valid_in = 1'b1;
        n_acc = 0; pulses = 0; last_acc = 0; prev_v = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (bus.result_valid_out) begin
                pulses++;
                if (prev_v) check("stream_pulse_width", 128'(prev_v), 128'd0);
                if (exp_q.size() > 0) check("stream_result", bus.result_out, exp_q.pop_front());
                else check("stream_extra_pulse", 128'd1, 128'd0);
            end
            prev_v = bus.result_valid_out;
            accepted = bus.data_valid_in && bus.data_ready_out;
            if (accepted) begin
                if (n_acc > 0) check("stream_interval", 128'(c - last_acc), 128'd34);
                last_acc = c;
                n_acc++;
                exp_q.push_back(sm4_ref(kat_rks, cur_sel, cur));
            end
            @(negedge clk);
            if (accepted) begin
                if (n_acc == 3) bus.data_valid_in = 1'b0;
                else begin
                    cur = rnd128(); cur_sel = 1'($urandom_range(0, 1));
                    bus.data_in = cur; bus.encdec_sel_in = cur_sel;
                end
            end
            if (n_acc == 3 && pulses == 3) break;
        end
        bus.data_valid_in = 1'b0;
        check("stream_pulses", 128'(pulses), 128'd3);
        check("stream_queue_empty", 128'(exp_q.size()), 128'd0);
        prev_res = bus.result_out;

        // ---- enable dropped at round 10 ----
        start_block(1'b0, rnd128());
        repeat (10) @(negedge clk);
        sm4_enable_in = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_valid_out) seen++;
        end
        check("abort_en_no_valid", 128'(seen), 128'd0);
        check("abort_en_result_kept", bus.result_out, prev_res);
        sm4_enable_in = 1'b1;
        @(negedge clk);
        check("abort_en_ready_back", 128'(bus.data_ready_out), 128'd1);

        // ---- key-finished dropped while the result is being formed ----
        start_block(1'b1, rnd128());
        repeat (32) @(negedge clk);
        key_exp_finished_in = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.result_valid_out) seen++;
        end
        check("abort_out_no_valid", 128'(seen), 128'd0);
        check("abort_out_result_kept", bus.result_out, prev_res);
        key_exp_finished_in = 1'b1;
        #1;
        check("abort_out_ready_back", 128'(bus.data_ready_out), 128'd1);

        // ---- reset at round 20, then the known-answer vector again ----
        start_block(1'b0, rnd128());
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_result_out", bus.result_out, 128'd0);
        check("midreset_result_valid", 128'(bus.result_valid_out), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        start_block(1'b0, KAT_KEY);
        wait_result(res, lat, got);
        check("postreset_valid", 128'(got), 128'd1);
        check("postreset_result", res, KAT_CT);
        check("postreset_latency", 128'(lat), 128'd33);

`ifdef SM4_OUT_HANDSHAKE_EN
        // ---- output back-pressure ----
        @(negedge clk);
        bus.result_ready_in = 1'b0;
        start_block(1'b1, KAT_CT);
        wait_result(res, lat, got);
        check("hs_latency", 128'(lat), 128'd33);
        check("hs_result", res, KAT_KEY);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hs_hold_valid%0d", i), 128'(bus.result_valid_out), 128'd1);
            check($sformatf("hs_hold_data%0d", i), bus.result_out, KAT_KEY);
            check($sformatf("hs_not_ready%0d", i), 128'(bus.data_ready_out), 128'd0);
        end
        bus.result_ready_in = 1'b1;
        @(negedge clk);
        check("hs_valid_drop", 128'(bus.result_valid_out), 128'd0);
        check("hs_idle_ready", 128'(bus.data_ready_out), 128'd1);
        check("hs_result_kept", bus.result_out, KAT_KEY);
`endif

        // ---- final report ----
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
